imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter ZICSR_EN, default 1, enables CSR zimm decode.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  instruction word presented.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port instr  input  32  RV32I/RV64I instruction word.
REQ-009 SHALL have port out_valid  output  1  decoded entry available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the entry this cycle.
REQ-011 SHALL have port imm  output  XLEN  decoded immediate.
REQ-012 SHALL have port imm_type  output  3  format: NONE=0, I=1, SH=2, S=3, B=4, U=5, J=6, Z=7.
REQ-013 SHALL have port imm_illegal  output  1  malformed or unknown encoding.

Function
REQ-014 Decode: I-type (OP-IMM non-shift, LOAD, JALR) SHALL sign-extend instr[31:20] to XLEN, type I.
REQ-015 OP-IMM func3 001/101 SHALL zero-extend shamt, type SH: instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
REQ-016 XLEN=32 shift with instr[25]=1 SHALL set imm_illegal=1, imm uses instr[24:20] only.
REQ-017 S, B, J SHALL use standard RISC-V bit scatter, sign-extended from instr[31] to XLEN; B and J bit0=0.
REQ-018 LUI/AUIPC SHALL produce {instr[31:12],12'b0} sign-extended from instr[31] to XLEN, type U.
REQ-019 SYSTEM (1110011) with func3[2]=1 and ZICSR_EN=1 SHALL zero-extend instr[19:15], type Z; other SYSTEM: imm=0, type NONE.
REQ-020 OP (0110011) and MISC-MEM (0001111) SHALL give imm=0, type NONE, illegal=0.
REQ-021 Any other opcode, or instr[1:0]!=2'b11, SHALL give imm=0, type NONE, imm_illegal=1.
REQ-022 Buffer: 2-entry FIFO of {imm, imm_type, imm_illegal}; count 0..2.
REQ-023 Push when in_valid&&in_ready; pop when out_valid&&out_ready.
REQ-024 in_ready SHALL equal (count<2) && !rst, combinational from registered count only.
REQ-025 Latency SHALL be 1 cycle: word accepted at edge k into empty FIFO is out_valid after edge k.
REQ-026 out_valid SHALL equal (count!=0); outputs reflect head entry and stay stable while out_valid&&!out_ready.
REQ-027 When out_valid=0, imm, imm_type, imm_illegal SHALL be 0.
REQ-028 Simultaneous push and pop at count=1 SHALL keep count=1 with new entry at head next cycle; sustained throughput 1 word/cycle.
REQ-029 At count=2 no push occurs; pop at count=0 impossible; order strictly FIFO.
REQ-030 flush SHALL set count=0 next edge, overriding same-cycle push and pop; the pushed word is dropped.

Reset
REQ-031 rst assertion SHALL immediately clear count to 0: out_valid=0, imm=0, imm_type=NONE, imm_illegal=0, in_ready=0.
REQ-032 Reset mid-stream SHALL discard all entries; in_ready=1 first cycle after rst deasserts.

Structure
REQ-033 Shared package imm_pkg SHALL hold opcode localparams and the imm_type_t enum (3-bit).
REQ-034 Combinational decode SHALL be sub-module imm_decode (params XLEN, ZICSR_EN), feeding the FIFO in imm_gen_pipe.

Verification
REQ-035 XLEN=32, push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle imm=0xFFFFFFFF, type I, illegal 0.
REQ-036 Push 0x02009093: XLEN=32 -> imm=0, type SH, illegal 1; XLEN=64 -> imm=32, illegal 0.
REQ-037 XLEN=32 push 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, type B; XLEN=64 push 0x800000B7 (lui) -> imm=0xFFFFFFFF80000000, type U.
REQ-038 Push 0x300FD0F3 (csrrwi x1,mstatus,31) -> imm=0x1F, type Z; with ZICSR_EN=0 -> imm=0, type NONE.
REQ-039 out_ready=0, in_valid=1 for 3 words -> two accepted, in_ready=0 on third, head held; out_ready=1 -> drains in order, third accepted.
REQ-040 count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, word dropped; rst asserted mid-stream -> same, asynchronously.

Source files
------------

// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg -- shared definitions for the immediate generator pipeline.
//   * RV32I/RV64I major opcode constants (instr[6:0]).
//   * imm_type_t: 3-bit immediate format tag carried alongside each decoded
//     immediate (NONE=0, I=1, SH=2, S=3, B=4, U=5, J=6, Z=7).
// -----------------------------------------------------------------------------
package imm_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_SH   = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_U    = 3'd5,
    IMM_J    = 3'd6,
    IMM_Z    = 3'd7
  } imm_type_t;

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode -- purely combinational RISC-V immediate decoder.
// Parameters:
//   XLEN     : immediate width, 32 or 64.
//   ZICSR_EN : nonzero enables decode of the CSR 5-bit zimm field.
// Ports:
//   instr       in  32    instruction word
//   imm         out XLEN  decoded immediate (0 for formats without one)
//   imm_type    out 3     format tag (imm_type_t)
//   imm_illegal out 1     malformed or unknown encoding
// -----------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ZICSR_EN = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_t       imm_type,
  output logic            imm_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Sign-extend a 32-bit value to XLEN; identity when XLEN is 32.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Every legal opcode ends in 2'b11, so matching the full 7-bit opcode also
  // rejects compressed/malformed words through the default arm.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned; that is what keeps this block free of inferred latches.
    imm         = '0;
    imm_type    = IMM_NONE;
    imm_illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm      = sext32({{20{instr[31]}}, instr[31:20]});
        imm_type = IMM_I;
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_type = IMM_SH;
          if (XLEN == 64) begin
            imm[5:0] = instr[25:20];
          end else begin
            // RV32 shamt is 5 bits; a set bit 25 is an illegal encoding.
            imm[4:0]    = instr[24:20];
            imm_illegal = instr[25];
          end
        end else begin
          imm      = sext32({{20{instr[31]}}, instr[31:20]});
          imm_type = IMM_I;
        end
      end
      OPC_STORE: begin
        imm      = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        imm      = sext32({{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0});
        imm_type = IMM_B;
      end
      OPC_JAL: begin
        imm      = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0});
        imm_type = IMM_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm      = sext32({instr[31:12], 12'b0});
        imm_type = IMM_U;
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the immediate CSR forms (csrrwi/csrrsi/csrrci).
        if (ZICSR_EN != 0 && funct3[2]) begin
          imm[4:0] = instr[19:15];
          imm_type = IMM_Z;
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
        // Legal, no immediate: defaults stand.
      end
      default: begin
        imm_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe -- immediate decoder followed by a 2-entry ready/valid FIFO.
// A word accepted on edge k into an empty FIFO is presented after edge k;
// simultaneous push/pop sustains one word per cycle.
// Parameters: XLEN (32 or 64), ZICSR_EN (CSR zimm decode enable).
// Ports:
//   clk, rst     single clock; asynchronous active-high reset
//   flush        synchronous discard of all buffered entries (beats push/pop)
//   in_valid/in_ready/instr      input handshake and instruction word
//   out_valid/out_ready          output handshake
//   imm, imm_type, imm_illegal   head entry; all zero while out_valid=0
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ZICSR_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            imm_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_type;
  logic            dec_illegal;

  imm_decode #(
    .XLEN     (XLEN),
    .ZICSR_EN (ZICSR_EN)
  ) u_decode (
    .instr       (instr),
    .imm         (dec_imm),
    .imm_type    (dec_type),
    .imm_illegal (dec_illegal)
  );

  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [XLEN-1:0] imm_mem  [2];
  imm_type_t       type_mem [2];
  logic            ill_mem  [2];

  logic push;
  logic pop;

  // Ready depends only on registered occupancy (plus reset), never on
  // out_ready, so no combinational path runs from consumer to producer.
  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; occupancy is reset and the outputs are
  // gated by out_valid, so stale contents are never observable. A write that
  // coincides with flush lands in a slot that count already marks empty.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr]  <= dec_imm;
      type_mem[wr_ptr] <= dec_type;
      ill_mem[wr_ptr]  <= dec_illegal;
    end
  end

  always_comb begin
    imm         = '0;
    imm_type    = IMM_NONE;
    imm_illegal = 1'b0;
    if (out_valid) begin
      imm         = imm_mem[rd_ptr];
      imm_type    = type_mem[rd_ptr];
      imm_illegal = ill_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe -- scoreboard bench for imm_gen_pipe.
// Three instances share stimulus: A (XLEN=32, ZICSR_EN=1), B (XLEN=64,
// ZICSR_EN=1), C (XLEN=32, ZICSR_EN=0). Each accepted word pushes its vector
// index into a per-instance queue; the monitor compares the head entry of
// every instance on each falling edge and pops on handshake.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_SH = 3'd2, T_S = 3'd3,
                         T_B = 3'd4, T_U = 3'd5, T_J = 3'd6, T_Z = 3'd7;
  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'h0;

  logic        ir_a, ov_a, il_a;
  logic [31:0] imm_a;
  logic [2:0]  ty_a;
  logic        ir_b, ov_b, il_b;
  logic [63:0] imm_b;
  logic [2:0]  ty_b;
  logic        ir_c, ov_c, il_c;
  logic [31:0] imm_c;
  logic [2:0]  ty_c;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ZICSR_EN(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .instr(instr), .out_valid(ov_a), .out_ready(out_ready), .imm(imm_a),
    .imm_type(ty_a), .imm_illegal(il_a));

  imm_gen_pipe #(.XLEN(64), .ZICSR_EN(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .instr(instr), .out_valid(ov_b), .out_ready(out_ready), .imm(imm_b),
    .imm_type(ty_b), .imm_illegal(il_b));

  imm_gen_pipe #(.XLEN(32), .ZICSR_EN(0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
    .instr(instr), .out_valid(ov_c), .out_ready(out_ready), .imm(imm_c),
    .imm_type(ty_c), .imm_illegal(il_c));

  // Hand-computed vectors: [0]=A, [1]=B, [2]=C.
  logic [31:0] v_instr [NV];
  logic [63:0] v_imm   [3][NV];
  logic [2:0]  v_ty    [3][NV];
  logic        v_ill   [3][NV];

  int n_chk  = 0;
  int n_pass = 0;
  int n_push = 0;
  int cur_idx = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic setv(input int i, input logic [31:0] ins,
                      input logic [63:0] ia, input logic [2:0] ta, input logic la,
                      input logic [63:0] ib, input logic [2:0] tb, input logic lb,
                      input logic [63:0] ic, input logic [2:0] tc, input logic lc);
    v_instr[i] = ins;
    v_imm[0][i] = ia; v_ty[0][i] = ta; v_ill[0][i] = la;
    v_imm[1][i] = ib; v_ty[1][i] = tb; v_ill[1][i] = lb;
    v_imm[2][i] = ic; v_ty[2][i] = tc; v_ill[2][i] = lc;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue side: record every word the DUTs will accept on the next edge.
  always @(negedge clk) begin
    if (!rst && in_valid && !flush) begin
      if (ir_a) begin q0.push_back(cur_idx); n_push++; end
      if (ir_b) q1.push_back(cur_idx);
      if (ir_c) q2.push_back(cur_idx);
    end
  end

  // Monitor: compare each instance's head against its scoreboard queue.
  always @(negedge clk) begin : monitor
    logic [63:0] ia;
    logic [2:0]  ta;
    logic        la, va;
    int          qs, idx;
    for (int id = 0; id < 3; id++) begin
      case (id)
        0:       begin va = ov_a; ia = {32'h0, imm_a}; ta = ty_a; la = il_a; qs = q0.size(); idx = (qs > 0) ? q0[0] : 0; end
        1:       begin va = ov_b; ia = imm_b;          ta = ty_b; la = il_b; qs = q1.size(); idx = (qs > 0) ? q1[0] : 0; end
        default: begin va = ov_c; ia = {32'h0, imm_c}; ta = ty_c; la = il_c; qs = q2.size(); idx = (qs > 0) ? q2[0] : 0; end
      endcase
      if (va) begin
        if (qs == 0) begin
          check($sformatf("dut%0d unexpected out_valid", id), 64'(va), 64'(0));
        end else begin
          check($sformatf("dut%0d vec%0d imm", id, idx), ia, v_imm[id][idx]);
          check($sformatf("dut%0d vec%0d type", id, idx), 64'(ta), 64'(v_ty[id][idx]));
          check($sformatf("dut%0d vec%0d illegal", id, idx), 64'(la), 64'(v_ill[id][idx]));
        end
      end else begin
        check($sformatf("dut%0d idle outputs", id), {ia[59:0], ta, la}, 64'(0));
      end
    end
    if (flush) begin
      q0.delete(); q1.delete(); q2.delete();
    end else if (out_ready && !rst) begin
      if (ov_a && q0.size() > 0) void'(q0.pop_front());
      if (ov_b && q1.size() > 0) void'(q1.pop_front());
      if (ov_c && q2.size() > 0) void'(q2.pop_front());
    end
  end

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!ov_a && !ov_b && !ov_c && q0.size() == 0) begin done = 1'b1; break; end
    end
    check(name, 64'(done), 64'(1));
    sync();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic got;
    //        instr         A imm                 type  il  B imm                 type  il  C imm                 type  il
    setv( 0, 32'hFFF00093, 64'hFFFFFFFF,         T_I,  0, 64'hFFFFFFFFFFFFFFFF, T_I,  0, 64'hFFFFFFFF,         T_I,  0);
    setv( 1, 32'h02009093, 64'h0,                T_SH, 1, 64'h20,               T_SH, 0, 64'h0,                T_SH, 1);
    setv( 2, 32'hFE000EE3, 64'hFFFFFFFC,         T_B,  0, 64'hFFFFFFFFFFFFFFFC, T_B,  0, 64'hFFFFFFFC,         T_B,  0);
    setv( 3, 32'h800000B7, 64'h80000000,         T_U,  0, 64'hFFFFFFFF80000000, T_U,  0, 64'h80000000,         T_U,  0);
    setv( 4, 32'h300FD0F3, 64'h1F,               T_Z,  0, 64'h1F,               T_Z,  0, 64'h0,                T_NONE, 0);
    setv( 5, 32'hFE20AC23, 64'hFFFFFFF8,         T_S,  0, 64'hFFFFFFFFFFFFFFF8, T_S,  0, 64'hFFFFFFF8,         T_S,  0);
    setv( 6, 32'h0080006F, 64'h8,                T_J,  0, 64'h8,                T_J,  0, 64'h8,                T_J,  0);
    setv( 7, 32'h003100B3, 64'h0,                T_NONE, 0, 64'h0,              T_NONE, 0, 64'h0,              T_NONE, 0);
    setv( 8, 32'h00000000, 64'h0,                T_NONE, 1, 64'h0,              T_NONE, 1, 64'h0,              T_NONE, 1);
    setv( 9, 32'h0000005B, 64'h0,                T_NONE, 1, 64'h0,              T_NONE, 1, 64'h0,              T_NONE, 1);
    setv(10, 32'h80012083, 64'hFFFFF800,         T_I,  0, 64'hFFFFFFFFFFFFF800, T_I,  0, 64'hFFFFF800,         T_I,  0);
    setv(11, 32'h00000073, 64'h0,                T_NONE, 0, 64'h0,              T_NONE, 0, 64'h0,              T_NONE, 0);
    setv(12, 32'h43F0D093, 64'h1F,               T_SH, 1, 64'h3F,               T_SH, 0, 64'h1F,               T_SH, 1);
    setv(13, 32'h00001297, 64'h1000,             T_U,  0, 64'h1000,             T_U,  0, 64'h1000,             T_U,  0);
    setv(14, 32'h300020F3, 64'h0,                T_NONE, 0, 64'h0,              T_NONE, 0, 64'h0,              T_NONE, 0);
    setv(15, 32'h0FF0000F, 64'h0,                T_NONE, 0, 64'h0,              T_NONE, 0, 64'h0,              T_NONE, 0);

    // Reset state while rst is held.
    #2;
    check("reset in_ready", 64'(ir_a), 64'(0));
    check("reset out_valid", 64'(ov_a), 64'(0));
    check("reset outputs", {imm_a, 29'h0, ty_a, il_a} , 64'(0));
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 64'(ir_a), 64'(1));

    // Back-to-back stream at full throughput.
    sync();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      cur_idx = i; instr = v_instr[i]; in_valid = 1'b1;
      sync();
    end
    in_valid = 1'b0;
    check("throughput accepted words", 64'(n_push), 64'(NV));
    wait_drain("stream drained");

    // Backpressure: three words offered with the consumer stalled.
    out_ready = 1'b0; in_valid = 1'b1;
    cur_idx = 0; instr = v_instr[0]; sync();
    cur_idx = 1; instr = v_instr[1]; sync();
    cur_idx = 2; instr = v_instr[2];
    @(negedge clk);
    check("full in_ready", 64'(ir_a), 64'(0));
    check("full head imm", 64'(imm_a), v_imm[0][0]);
    sync();
    @(negedge clk);
    check("stall held in_ready", 64'(ir_b), 64'(0));
    check("stall held head", imm_b, v_imm[1][0]);
    sync();
    out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ir_a) begin got = 1'b1; break; end
    end
    check("third word accepted", 64'(got), 64'(1));
    sync();
    in_valid = 1'b0;
    wait_drain("backpressure drained");

    // Flush at count=2 with a word offered, then at count=1 with a live push.
    out_ready = 1'b0; in_valid = 1'b1;
    cur_idx = 3; instr = v_instr[3]; sync();
    cur_idx = 4; instr = v_instr[4]; sync();
    cur_idx = 5; instr = v_instr[5]; flush = 1'b1; out_ready = 1'b1; sync();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush full out_valid", 64'({ov_a, ov_b, ov_c}), 64'(0));
    check("flush full in_ready", 64'(ir_a), 64'(1));
    sync();
    out_ready = 1'b0; in_valid = 1'b1;
    cur_idx = 6; instr = v_instr[6]; sync();
    cur_idx = 7; instr = v_instr[7]; flush = 1'b1; out_ready = 1'b1; sync();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush drops pushed word", 64'({ov_a, ov_b, ov_c}), 64'(0));
    sync();

    // Reset asserted mid-stream, between clock edges.
    out_ready = 1'b0; in_valid = 1'b1;
    cur_idx = 9; instr = v_instr[9]; sync();
    cur_idx = 1; instr = v_instr[1]; sync();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    check("async reset out_valid", 64'({ov_a, ov_b, ov_c}), 64'(0));
    check("async reset in_ready", 64'({ir_a, ir_b, ir_c}), 64'(0));
    check("async reset outputs", {imm_a, 29'h0, ty_a, il_a}, 64'(0));
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after mid reset", 64'(ir_a), 64'(1));
    sync();
    out_ready = 1'b1; in_valid = 1'b1;
    cur_idx = 13; instr = v_instr[13]; sync();
    in_valid = 1'b0;
    wait_drain("post-reset drained");

    check("scoreboard A empty", 64'(q0.size()), 64'(0));
    check("scoreboard B empty", 64'(q1.size()), 64'(0));
    check("scoreboard C empty", 64'(q2.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
